toggle_sync_rx_multi: RTL and testbench
=======================================

Name: toggle_sync_rx_multi

Overview:
Multi-channel receive side of a toggle-based CDC pulse synchroniser, running entirely in the destination clock domain. Each channel takes a toggle line from an asynchronous source domain and passes it through a SYNC_STAGES-deep synchroniser. Every transition is converted into a one-cycle pulse, a sticky pending flag with overflow detection, and a saturating event count. A post-reset capture window suppresses the spurious pulse that would otherwise appear when a source toggle is already high at reset release.

Parameters:
CHANNELS, 4, number of independent toggle channels (>=1)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
CNT_W, 8, width of per-channel saturating event counter (>=1)

Ports:
clk_i  input  1  destination clock; the only clock in the block
arst_n_i  input  1  asynchronous active-low reset; deassertion is synchronised externally
tog_i  input  CHANNELS  asynchronous toggle lines; each transition (either polarity) is one event
pulse_o  output  CHANNELS  one-cycle pulse per detected event
pending_o  output  CHANNELS  sticky event flag per channel
clr_i  input  CHANNELS  per-channel clear of pending_o and ovf_o, sampled on clk_i
ovf_o  output  CHANNELS  sticky flag: event arrived while pending was already set
cnt_clr_i  input  1  synchronous clear of all event counters
cnt_o  output  CHANNELS*CNT_W  event counters; channel c occupies bits [c*CNT_W +: CNT_W]
ready_o  output  1  high once the post-reset capture window has ended

Behaviour:
- Reset (arst_n_i=0): all synchroniser flops, the previous-value register, pulse_o, pending_o, ovf_o, cnt_o, ready_o and the window counter go to 0 immediately.
- Per channel, on every edge: s[1]<=tog_i[c]; s[i]<=s[i-1]; prev<=s[SYNC_STAGES]. Event condition ev = s[SYNC_STAGES]^prev.
- Capture window: covers the first SYNC_STAGES+1 rising edges after reset release.
  - Synchroniser and prev load normally.
  - ev is ignored: no pulse, pending, ovf or counter update.
  - ready_o rises at the edge that ends the window and stays 1 until reset.
  - A tog_i line held static through reset therefore never produces an event.
- Latency: tog_i changes and meets setup before edge k. pulse_o is registered and is high for exactly the one cycle following edge k+SYNC_STAGES. Each transition yields exactly one pulse.
- Throughput: transitions must be spaced by at least 2 clk_i periods plus metastability margin. Closer transitions may merge; a double toggle between samples produces zero events. This is a source-side rule, not checked by the block.
- pending_o[c]: set on ev. Cleared at the edge where clr_i[c]=1. If set and clear occur on the same edge, set wins and pending stays 1.
- ovf_o[c]: set when ev occurs while pending_o[c]=1 and clr_i[c]=0 on that edge. Cleared by clr_i[c]; set wins on a simultaneous set and clear.
  - ev together with clr_i[c]=1 while pending: pending stays 1, ovf is not set (the event is counted as the new pending event).
- cnt_o channel c: +1 on ev, saturating at 2^CNT_W-1 with no wrap.
  - cnt_clr_i=1 loads 0; if ev occurs on the same edge, it loads 1.
  - cnt_clr_i and clr_i are independent.
- Channels are fully independent; simultaneous events on any subset are all handled on the same edge.
- Reset mid-operation: all state is lost immediately. In-flight transitions are discarded, and the capture window restarts on release.
- No combinational path from any input to any output.

Test Plan:
(CHANNELS=4, SYNC_STAGES=2, CNT_W=4; clk_i 50 MHz; tog_i driven from an unrelated 500 MHz domain)
- Reset release with tog_i=4'b1010 held -> ready_o=1 after 3rd edge; pulse_o, pending_o, ovf_o stay 0 and cnt_o=0 for 100 cycles.
- Single toggle of tog_i[0] just before edge k -> pulse_o[0]=1 only in cycle after edge k+2; pending_o[0]=1 from then on; cnt_o[3:0]=1.
- Toggle ch1 twice, each 20 cycles apart, no clr_i -> two pulses; pending_o[1]=1; ovf_o[1]=1; cnt ch1=2. Then clr_i[1] one cycle -> pending_o[1]=0, ovf_o[1]=0.
- 20 toggles on ch2 -> cnt ch2 saturates at 15. Then cnt_clr_i on the same edge as an event -> cnt ch2=1.
- clr_i[3] asserted on the edge an event is detected, with pending_o[3] already 1 -> pending_o[3] stays 1, ovf_o[3] stays 0.
- Toggles on all 4 channels in the same source cycle -> pulse_o=4'b1111 in one cycle. Then arst_n_i pulsed low with a toggle in flight -> no pulse after release; outputs 0 until the next new toggle.

Source files
------------

// File: rtl/toggle_sync_rx_multi.sv
// rtl/toggle_sync_rx_multi.sv - multi-channel toggle-to-pulse CDC receiver with pending, overflow and event counters
module toggle_sync_rx_multi #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                      clk_i,
  input  logic                      arst_n_i,
  input  logic [CHANNELS-1:0]       tog_i,
  output logic [CHANNELS-1:0]       pulse_o,
  output logic [CHANNELS-1:0]       pending_o,
  input  logic [CHANNELS-1:0]       clr_i,
  output logic [CHANNELS-1:0]       ovf_o,
  input  logic                      cnt_clr_i,
  output logic [CHANNELS*CNT_W-1:0] cnt_o,
  output logic                      ready_o
);

  localparam int WIN_W = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [CHANNELS-1:0]    prev_q;
  logic [CHANNELS-1:0]    ev;
  logic [WIN_W-1:0]       win_q;
  logic [CNT_W-1:0]       cnt_q [CHANNELS];

  // Events are masked until ready_o, which hides the edge seen when a line is already high at release.
  always_comb begin
    ev = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      ev[c] = ready_o & (sync_q[c][SYNC_STAGES-1] ^ prev_q[c]);
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      win_q   <= '0;
      ready_o <= 1'b0;
    end else if (!ready_o) begin
      win_q <= win_q + WIN_W'(1);
      if (win_q == WIN_LAST) begin
        ready_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      prev_q    <= '0;
      pulse_o   <= '0;
      pending_o <= '0;
      ovf_o     <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c] <= '0;
        cnt_q[c]  <= '0;
      end
    end else begin
      pulse_o   <= ev;
      pending_o <= ev | (pending_o & ~clr_i);
      ovf_o     <= (ev & pending_o & ~clr_i) | (ovf_o & ~clr_i);
      for (int c = 0; c < CHANNELS; c++) begin
        sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], tog_i[c]};
        prev_q[c] <= sync_q[c][SYNC_STAGES-1];
        if (cnt_clr_i) begin
          cnt_q[c] <= ev[c] ? CNT_W'(1) : '0;
        end else if (ev[c] && (cnt_q[c] != CNT_MAX)) begin
          cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_cnt
    assign cnt_o[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_toggle_sync_rx_multi.sv
// tb/tb_toggle_sync_rx_multi.sv - randomized self-checking bench for toggle_sync_rx_multi
module tb_toggle_sync_rx_multi;

  localparam int C = 4;
  localparam int S = 2;
  localparam int W = 4;
  localparam int CMAX = 15;

  logic         clk = 1'b0;
  logic         arst_n = 1'b0;
  logic [C-1:0] tog = 4'b1010;
  logic [C-1:0] clr = '0;
  logic         cnt_clr = 1'b0;
  logic [C-1:0] pulse, pending, ovf;
  logic [C*W-1:0] cnt;
  logic         ready;

  int n_cmp = 0;
  int n_err = 0;

  toggle_sync_rx_multi #(.CHANNELS(C), .SYNC_STAGES(S), .CNT_W(W)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .tog_i    (tog),
    .pulse_o  (pulse),
    .pending_o(pending),
    .clr_i    (clr),
    .ovf_o    (ovf),
    .cnt_clr_i(cnt_clr),
    .cnt_o    (cnt),
    .ready_o  (ready)
  );

  always #10 clk = ~clk;

  // Reference: samples of tog_i taken at each edge since release; an event shows at edge m
  // when the samples at m-S and m-S-1 differ, and only once the capture window is over.
  int           m_edge;
  logic [C-1:0] m_samp [$];
  logic [C-1:0] m_pulse, m_pend, m_ovf;
  int           m_cnt [C];
  logic         m_ready;

  task automatic model_reset();
    m_edge = 0;
    m_samp.delete();
    m_samp.push_back('0);
    m_pulse = '0;
    m_pend  = '0;
    m_ovf   = '0;
    m_ready = 1'b0;
    for (int c = 0; c < C; c++) m_cnt[c] = 0;
  endtask

  task automatic model_step();
    logic [C-1:0] evs;
    m_edge++;
    m_samp.push_back(tog);
    evs = '0;
    if (m_edge >= S + 2) evs = m_samp[m_edge-S] ^ m_samp[m_edge-S-1];
    for (int c = 0; c < C; c++) begin
      m_ovf[c]  = (evs[c] && m_pend[c] && !clr[c]) || (m_ovf[c] && !clr[c]);
      m_pend[c] = evs[c] || (m_pend[c] && !clr[c]);
      if (cnt_clr) m_cnt[c] = evs[c] ? 1 : 0;
      else if (evs[c] && m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
    end
    m_pulse = evs;
    m_ready = (m_edge >= S + 1);
  endtask

  function automatic logic [C*W-1:0] m_cnt_vec();
    logic [C*W-1:0] v;
    for (int c = 0; c < C; c++) v[c*W +: W] = m_cnt[c][W-1:0];
    return v;
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge arst_n);
      if (!arst_n) model_reset();
      else model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("pulse",   32'(pulse),   32'(m_pulse));
      check("pending", 32'(pending), 32'(m_pend));
      check("ovf",     32'(ovf),     32'(m_ovf));
      check("cnt",     32'(cnt),     32'(m_cnt_vec()));
      check("ready",   32'(ready),   32'(m_ready));
    end
  end

  // Moves to a point between a falling and the next rising edge, clear of both.
  task automatic slot();
    @(negedge clk);
    #($urandom_range(1, 7));
  endtask

  int  last_t [C];
  bit  seen;

  initial begin
    // Static-high lines through reset release
    repeat (3) @(negedge clk);
    slot();
    arst_n = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("ready_edge2", 32'(ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("ready_edge3", 32'(ready), 32'd1);
    repeat (100) @(negedge clk);
    check("static_pending", 32'(pending), 32'd0);
    check("static_cnt", 32'(cnt), 32'd0);

    // Single toggle latency on ch0
    slot();
    tog[0] = ~tog[0];
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("pulse0_k1", 32'(pulse[0]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("pulse0_k2", 32'(pulse[0]), 32'd1);
    @(negedge clk);
    check("pulse0_after", 32'(pulse[0]), 32'd0);
    check("pending0", 32'(pending[0]), 32'd1);
    check("cnt0", 32'(cnt[3:0]), 32'd1);

    // Two events on ch1 without clear, then clear
    slot();
    tog[1] = ~tog[1];
    repeat (19) @(negedge clk);
    slot();
    tog[1] = ~tog[1];
    repeat (5) @(negedge clk);
    check("pending1", 32'(pending[1]), 32'd1);
    check("ovf1", 32'(ovf[1]), 32'd1);
    check("cnt1", 32'(cnt[7:4]), 32'd2);
    slot();
    clr[1] = 1'b1;
    slot();
    clr[1] = 1'b0;
    @(negedge clk);
    check("pending1_clr", 32'(pending[1]), 32'd0);
    check("ovf1_clr", 32'(ovf[1]), 32'd0);

    // Double toggle between samples yields no event
    slot();
    tog[1] = ~tog[1];
    #1 tog[1] = ~tog[1];
    repeat (6) @(negedge clk);
    check("cnt1_double", 32'(cnt[7:4]), 32'd2);
    check("pending1_double", 32'(pending[1]), 32'd0);

    // Saturation on ch2, then counter clear coinciding with an event
    for (int i = 0; i < 20; i++) begin
      slot();
      tog[2] = ~tog[2];
      repeat ($urandom_range(2, 4)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    check("cnt2_sat", 32'(cnt[11:8]), 32'd15);
    slot();
    tog[2] = ~tog[2];
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 cnt_clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("cnt2_clr_ev", 32'(cnt[11:8]), 32'd1);
    check("cnt0_clr", 32'(cnt[3:0]), 32'd0);
    #1 cnt_clr = 1'b0;

    // Clear on the same edge as a new event while pending
    slot();
    tog[3] = ~tog[3];
    repeat (6) @(negedge clk);
    slot();
    tog[3] = ~tog[3];
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 clr[3] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("pulse3_clr", 32'(pulse[3]), 32'd1);
    check("pending3_clr", 32'(pending[3]), 32'd1);
    check("ovf3_clr", 32'(ovf[3]), 32'd0);
    #1 clr[3] = 1'b0;

    // All channels at once
    slot();
    tog = ~tog;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (pulse == 4'hF) seen = 1'b1;
    end
    check("all_pulse", 32'(seen), 32'd1);

    // Reset with a transition in flight
    slot();
    tog[0] = ~tog[0];
    slot();
    arst_n = 1'b0;
    slot();
    slot();
    arst_n = 1'b1;
    repeat (100) @(negedge clk);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);

    // Randomized traffic with spaced toggles, random clears and one mid-run reset
    for (int c = 0; c < C; c++) last_t[c] = -10;
    for (int cyc = 0; cyc < 600; cyc++) begin
      slot();
      for (int c = 0; c < C; c++) begin
        if ((cyc - last_t[c]) >= 3 && $urandom_range(0, 3) == 0) begin
          tog[c] = ~tog[c];
          last_t[c] = cyc;
        end
        clr[c] = ($urandom_range(0, 7) == 0);
      end
      cnt_clr = ($urandom_range(0, 31) == 0);
      if (cyc == 300) arst_n = 1'b0;
      if (cyc == 302) arst_n = 1'b1;
    end
    slot();
    clr = '0;
    cnt_clr = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
